// File: rtl/ad_emu_pkg.sv
// rtl/ad_emu_pkg.sv - shared constants, enums and LFSR step for the ADC emulator
package ad_emu_pkg;

  localparam logic [7:0] REG_MODE     = 8'h00;
  localparam logic [7:0] REG_CONST_L  = 8'h01;
  localparam logic [7:0] REG_CONST_H  = 8'h02;
  localparam logic [7:0] REG_STEP     = 8'h03;
  localparam logic [7:0] REG_FRAMES_L = 8'h04;
  localparam logic [7:0] REG_FRAMES_H = 8'h05;
  localparam logic [7:0] REG_SHORT    = 8'h06;

  typedef enum logic [1:0] {
    PAT_CONST  = 2'd0,
    PAT_RAMP   = 2'd1,
    PAT_SQUARE = 2'd2,
    PAT_LFSR   = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } frame_state_e;

  // Taps x^16+x^14+x^13+x^11+1 seen from a right-shifting register: bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/ad_emu_if.sv
// rtl/ad_emu_if.sv - serial read pins and fx register bus of the ADC emulator
interface ad_emu_if;
  logic        cs_n;
  logic        sclk;
  logic        sdata;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (
    output cs_n, sclk, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
    input  sdata, fx_q
  );

  modport slave (
    input  cs_n, sclk, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
    output sdata, fx_q
  );
endinterface

// File: rtl/ad_emu_pat.sv
// rtl/ad_emu_pat.sv - per-frame sample generator: constant, ramp, square, LFSR
module ad_emu_pat
  import ad_emu_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  pat_mode_e   mode,
  input  logic [15:0] const_val,
  input  logic [7:0]  step,
  input  logic        advance,
  input  logic        restart,
  output logic [15:0] sample
);

  logic [15:0] acc;
  logic [15:0] lfsr;
  logic        phase;

  // All generators step together so a mode switch never depends on history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      lfsr  <= LFSR_SEED;
      phase <= 1'b0;
    end else if (restart) begin
      acc   <= '0;
      lfsr  <= LFSR_SEED;
      phase <= 1'b0;
    end else if (advance) begin
      acc   <= acc + {8'h00, step};
      lfsr  <= lfsr_next(lfsr);
      phase <= ~phase;
    end
  end

  always_comb begin
    sample = const_val;
    case (mode)
      PAT_RAMP:   sample = acc;
      PAT_SQUARE: sample = phase ? (~const_val + 16'd1) : const_val;
      PAT_LFSR:   sample = lfsr;
      default:    sample = const_val;
    endcase
  end

endmodule

// File: rtl/ad_emu.sv
// rtl/ad_emu.sv - ADC serial-read responder with fx register file
module ad_emu
  import ad_emu_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [5:0] dev_id,
  ad_emu_if.slave    bus
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
  logic                   cs_prev, sclk_prev, cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_fall;
  frame_state_e           state, state_n;
  logic [DATA_W-1:0]      shreg, shreg_n;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic                   sdata_q, sdata_n, frame_end, short_end;
  pat_mode_e              mode_r;
  logic [15:0]            const_r, frames_r, sample;
  logic [7:0]             step_r, short_r, fx_q_r, rd_data;
  logic                   wsel, rsel, mode_wr, short_wr;

  // cs_n synchronizer resets low: a reader holding cs_n low across reset cannot fake a frame start
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cs_sync   <= '0;
      sclk_sync <= '1;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_fall = sclk_prev & ~sclk_s;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sdata_q <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      sdata_q <= sdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    frame_end = 1'b0;
    short_end = 1'b0;
    if (state != ST_IDLE && cs_rise) begin
      state_n   = ST_IDLE;
      frame_end = 1'b1;
      short_end = (state == ST_SHIFT);
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            shreg_n   = DATA_W'(sample);
            bit_cnt_n = '0;
            state_n   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_fall) begin
            if (bit_cnt == LAST_BIT) begin
              state_n = ST_TAIL;
            end else begin
              shreg_n   = shreg << 1;
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    sdata_n = (state_n == ST_SHIFT) ? shreg_n[DATA_W-1] : 1'b0;
  end

  assign wsel     = bus.fx_wr && (bus.fx_waddr[21:16] == dev_id) && (bus.fx_waddr[15:8] == 8'h00);
  assign rsel     = bus.fx_rd && (bus.fx_raddr[21:16] == dev_id) && (bus.fx_raddr[15:8] == 8'h00);
  assign mode_wr  = wsel && (bus.fx_waddr[7:0] == REG_MODE);
  assign short_wr = wsel && (bus.fx_waddr[7:0] == REG_SHORT);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      mode_r   <= PAT_CONST;
      const_r  <= 16'h0000;
      step_r   <= 8'h01;
      frames_r <= 16'h0000;
      short_r  <= 8'h00;
    end else begin
      if (frame_end)
        frames_r <= frames_r + 16'd1;
      if (short_wr)
        short_r <= 8'h00;
      else if (short_end && short_r != 8'hFF)
        short_r <= short_r + 8'd1;
      if (wsel) begin
        case (bus.fx_waddr[7:0])
          REG_MODE:    mode_r         <= pat_mode_e'(bus.fx_data[1:0]);
          REG_CONST_L: const_r[7:0]   <= bus.fx_data;
          REG_CONST_H: const_r[15:8]  <= bus.fx_data;
          REG_STEP:    step_r         <= bus.fx_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.fx_raddr[7:0])
      REG_MODE:     rd_data = {6'b000000, mode_r};
      REG_CONST_L:  rd_data = const_r[7:0];
      REG_CONST_H:  rd_data = const_r[15:8];
      REG_STEP:     rd_data = step_r;
      REG_FRAMES_L: rd_data = frames_r[7:0];
      REG_FRAMES_H: rd_data = frames_r[15:8];
      REG_SHORT:    rd_data = short_r;
      default:      rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      fx_q_r <= 8'h00;
    else
      fx_q_r <= rsel ? rd_data : 8'h00;
  end

  assign bus.sdata = sdata_q;
  assign bus.fx_q  = fx_q_r;

  ad_emu_pat #(.LFSR_SEED(LFSR_SEED)) u_pat (
    .clk       (clk_sys),
    .rst       (rst),
    .mode      (mode_r),
    .const_val (const_r),
    .step      (step_r),
    .advance   (frame_end),
    .restart   (mode_wr),
    .sample    (sample)
  );

endmodule

// File: tb/tb_ad_emu.sv
// tb/tb_ad_emu.sv - reader model and pattern reference for ad_emu
module tb_ad_emu;
  import ad_emu_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] dev;
  int         checks = 0;
  int         errors = 0;

  ad_emu_if bus ();

  ad_emu #(.DATA_W(16), .SYNC_STAGES(SYNC), .LFSR_SEED(16'hACE1)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .dev_id  (dev),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: the sample of frame n after a restart, derived from the pattern rules
  int          m_mode, m_n;
  logic [15:0] m_const, m_frames, m_lfsr;
  logic [7:0]  m_step, m_short;

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] model_sample();
    case (m_mode)
      1:       return 16'(m_n * int'(m_step));
      2:       return (m_n % 2 == 1) ? 16'(17'h10000 - {1'b0, m_const}) : m_const;
      3:       return m_lfsr;
      default: return m_const;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_const = 16'h0000; m_step = 8'h01;
    m_frames = 16'h0000; m_short = 8'h00; m_lfsr = 16'hACE1;
  endtask

  task automatic model_end_frame(input int pulses);
    m_frames = m_frames + 16'd1;
    if (pulses < 16 && m_short != 8'hFF) m_short = m_short + 8'd1;
    m_n++;
    m_lfsr = lfsr_ref(m_lfsr);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fx_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.fx_waddr = {dev, 8'h00, addr};
    bus.fx_data  = data;
    bus.fx_wr    = 1'b1;
    @(negedge clk);
    bus.fx_wr = 1'b0;
    case (addr)
      REG_MODE:    begin m_mode = int'(data[1:0]); m_n = 0; m_lfsr = 16'hACE1; end
      REG_CONST_L: m_const[7:0] = data;
      REG_CONST_H: m_const[15:8] = data;
      REG_STEP:    m_step = data;
      REG_SHORT:   m_short = 8'h00;
      default: ;
    endcase
  endtask

  task automatic fx_read(input logic [7:0] addr, input logic [5:0] id, output logic [7:0] q);
    @(negedge clk);
    bus.fx_raddr = {id, 8'h00, addr};
    bus.fx_rd    = 1'b1;
    @(negedge clk);
    bus.fx_rd = 1'b0;
    q = bus.fx_q;
  endtask

  // ad_top-style read: MSB is valid from cs_n fall, each later bit from the preceding sclk rise
  task automatic do_frame(input string tag, input int pulses, input bit lat_chk,
                          output logic [15:0] word);
    logic [15:0] exp;
    exp  = model_sample();
    word = '0;
    @(negedge clk);
    bus.cs_n = 1'b0;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge clk);
      if (lat_chk && k <= SYNC + 1)
        check({tag, "_latency"}, bus.sdata, (k == SYNC + 1) ? exp[15] : 1'b0);
    end
    for (int i = 0; i < pulses; i++) begin
      word = {word[14:0], bus.sdata};
      bus.sclk = 1'b0; repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1; repeat (HALF) @(negedge clk);
    end
    bus.cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    if (pulses == 16) check(tag, word, exp);
    model_end_frame(pulses);
  endtask

  task automatic check_frames(input string tag);
    logic [7:0] q;
    fx_read(REG_FRAMES_L, dev, q); check({tag, "_frames_l"}, q, m_frames[7:0]);
    fx_read(REG_FRAMES_H, dev, q); check({tag, "_frames_h"}, q, m_frames[15:8]);
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  q;
    logic [15:0] rc;

    dev = 6'($urandom_range(0, 63));
    rst = 1'b1;
    bus.cs_n = 1'b1; bus.sclk = 1'b1;
    bus.fx_wr = 1'b0; bus.fx_rd = 1'b0;
    bus.fx_waddr = '0; bus.fx_raddr = '0; bus.fx_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sdata", bus.sdata, 1'b0);
    check("rst_fx_q", bus.fx_q, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fx_read(REG_MODE, dev, q);  check("rst_mode", q, 8'h00);
    fx_read(REG_STEP, dev, q);  check("rst_step", q, 8'h01);
    fx_read(REG_SHORT, dev, q); check("rst_short", q, 8'h00);

    // Constant pattern; sclk toggling while cs_n is high must be ignored
    repeat (3) begin
      bus.sclk = 1'b0; repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1; repeat (HALF) @(negedge clk);
    end
    fx_write(REG_CONST_L, 8'hC3);
    fx_write(REG_CONST_H, 8'hA5);
    do_frame("t1_const", 16, 1'b1, w);
    check("t1_word", w, 16'hA5C3);
    check_frames("t1");

    // Ramp with wrap; the middle frames are zero-pulse short frames
    fx_write(REG_STEP, 8'h10);
    fx_write(REG_MODE, 8'h01);
    do_frame("t2_ramp0", 16, 1'b0, w); check("t2_first", w, 16'h0000);
    do_frame("t2_ramp1", 16, 1'b0, w); check("t2_second", w, 16'h0010);
    repeat (4093) do_frame("t2_skip", 0, 1'b0, w);
    do_frame("t2_top", 16, 1'b0, w);  check("t2_fff0", w, 16'hFFF0);
    do_frame("t2_wrap", 16, 1'b0, w); check("t2_wrap0", w, 16'h0000);
    fx_read(REG_SHORT, dev, q); check("t2_short_sat", q, 8'hFF);
    check_frames("t2");

    // Square, including the self-negating 0x8000
    fx_write(REG_CONST_L, 8'h00);
    fx_write(REG_CONST_H, 8'h01);
    fx_write(REG_MODE, 8'h02);
    do_frame("t3_sq0", 16, 1'b0, w); check("t3_0100a", w, 16'h0100);
    do_frame("t3_sq1", 16, 1'b0, w); check("t3_ff00", w, 16'hFF00);
    do_frame("t3_sq2", 16, 1'b0, w); check("t3_0100b", w, 16'h0100);
    fx_write(REG_CONST_H, 8'h80);
    fx_write(REG_MODE, 8'h02);
    do_frame("t3_min0", 16, 1'b0, w); check("t3_8000a", w, 16'h8000);
    do_frame("t3_min1", 16, 1'b0, w); check("t3_8000b", w, 16'h8000);

    // LFSR over 1000 frames, full reads at random points
    fx_write(REG_MODE, 8'h03);
    do_frame("t4_lfsr0", 16, 1'b0, w); check("t4_ace1", w, 16'hACE1);
    do_frame("t4_lfsr1", 16, 1'b0, w); check("t4_5670", w, 16'h5670);
    for (int i = 2; i < 1000; i++) begin
      if (i == 999 || $urandom_range(0, 99) == 0)
        do_frame("t4_lfsr", 16, 1'b0, w);
      else
        do_frame("t4_skip", 0, 1'b0, w);
    end

    // Short frame counting and clear
    fx_write(REG_SHORT, 8'h00);
    do_frame("t5_short", 5, 1'b0, w);
    fx_read(REG_SHORT, dev, q); check("t5_short1", q, 8'h01);
    check_frames("t5");
    do_frame("t5_next", 16, 1'b0, w);
    fx_write(REG_SHORT, 8'h00);
    fx_read(REG_SHORT, dev, q); check("t5_short0", q, 8'h00);

    // Random configuration round
    rc = 16'($urandom);
    fx_write(REG_CONST_L, rc[7:0]);
    fx_write(REG_CONST_H, rc[15:8]);
    fx_write(REG_STEP, 8'($urandom));
    fx_write(REG_MODE, 8'($urandom_range(0, 3)));
    repeat (3) do_frame("rnd_frame", 16, 1'b0, w);

    // Reset after bit 7 of a frame carrying 0xFFFF
    fx_write(REG_CONST_L, 8'hFF);
    fx_write(REG_CONST_H, 8'hFF);
    fx_write(REG_MODE, 8'h00);
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    repeat (8) begin
      bus.sclk = 1'b0; repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1; repeat (HALF) @(negedge clk);
    end
    check("t6_pre_rst_sdata", bus.sdata, 1'b1);
    #2 rst = 1'b1;
    #1 check("t6_rst_sdata", bus.sdata, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    fx_read(REG_MODE, dev, q);    check("t6_mode", q, 8'h00);
    fx_read(REG_CONST_L, dev, q); check("t6_const_l", q, 8'h00);
    fx_read(REG_CONST_H, dev, q); check("t6_const_h", q, 8'h00);
    bus.cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    do_frame("t6_clean", 16, 1'b0, w); check("t6_zero", w, 16'h0000);
    check_frames("t6");
    fx_read(REG_FRAMES_L, dev ^ 6'h01, q); check("t6_wrong_dev", q, 8'h00);
    fx_read(8'h07, dev, q);                check("undef_addr", q, 8'h00);
    @(negedge clk);
    check("fx_q_idle", bus.fx_q, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
